// File: rtl/aec_pkg.sv
// Shared constants and types for the AEC expression feeder: ASCII codes,
// character classes, error codes and FSM states.
package aec_pkg;

   localparam int unsigned DEPTH     = 16;
   localparam int unsigned MAX_DEPTH = 7;
   localparam int unsigned TIMEOUT   = 255;
   localparam int unsigned IDX_W     = 4;
   localparam int unsigned DEPTH_W   = 3;
   localparam int unsigned TIMER_W   = 8;
   localparam int unsigned BYTE_W    = 8;

   localparam logic [7:0] CH_LP    = 8'h28;
   localparam logic [7:0] CH_RP    = 8'h29;
   localparam logic [7:0] CH_MUL   = 8'h2A;
   localparam logic [7:0] CH_ADD   = 8'h2B;
   localparam logic [7:0] CH_SUB   = 8'h2D;
   localparam logic [7:0] CH_EQ    = 8'h3D;
   localparam logic [7:0] CH_SP    = 8'h20;
   localparam logic [7:0] CH_0     = 8'h30;
   localparam logic [7:0] CH_9     = 8'h39;
   localparam logic [7:0] CH_A     = 8'h61;
   localparam logic [7:0] CH_F     = 8'h66;

   typedef enum logic [2:0] {
      CLS_OPND,
      CLS_OP,
      CLS_LP,
      CLS_RP,
      CLS_EQ,
      CLS_SP,
      CLS_BAD
   } char_class_t;

   typedef enum logic [1:0] {
      ERR_ILLEGAL  = 2'd0,
      ERR_SYNTAX   = 2'd1,
      ERR_OVERFLOW = 2'd2,
      ERR_TIMEOUT  = 2'd3
   } err_code_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_DISCARD,
      ST_SEND,
      ST_WAIT
   } state_t;

endpackage

// File: rtl/aec_char_classify.sv
// Combinational ASCII byte classifier for the expression feeder.
module aec_char_classify
   import aec_pkg::*;
(
   input  logic [7:0]  data,
   output char_class_t cls
);

   always_comb begin
      cls = CLS_BAD;
      if ((data >= CH_0 && data <= CH_9) || (data >= CH_A && data <= CH_F)) begin
         cls = CLS_OPND;
      end else begin
         case (data)
            CH_MUL, CH_ADD, CH_SUB: cls = CLS_OP;
            CH_LP:                  cls = CLS_LP;
            CH_RP:                  cls = CLS_RP;
            CH_EQ:                  cls = CLS_EQ;
            CH_SP:                  cls = CLS_SP;
            default:                cls = CLS_BAD;
         endcase
      end
   end

endmodule

// File: rtl/aec_expr_feeder.sv
// Host-side front end for AEC: buffers and checks one expression up to '=',
// replays it one char per cycle, then waits for AEC's result.
module aec_expr_feeder
   import aec_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       aec_ready,
   output logic [7:0] aec_ascii,
   input  logic       aec_valid,
   output logic       busy,
   output logic       err,
   output logic [1:0] err_code
);

   state_t                   state;
   char_class_t              cls;
   logic [BYTE_W-1:0]        buf_mem [DEPTH];
   logic [IDX_W-1:0]         wr_idx;
   logic [IDX_W-1:0]         rd_idx;
   logic [DEPTH_W-1:0]       depth;
   logic [TIMER_W-1:0]       timer;
   logic                     prev_opnd;

   logic                     xfer_c;
   logic                     bad_c;
   logic                     syn_c;
   logic                     ovf_c;
   logic [IDX_W-1:0]         rd_nxt_c;

   aec_char_classify u_classify (
      .data (in_data),
      .cls  (cls)
   );

   assign xfer_c   = in_valid & in_ready;
   assign rd_nxt_c = rd_idx + IDX_W'(1);

   // Grammar check of the incoming byte against the expression collected so far
   always_comb begin
      bad_c = (cls == CLS_BAD);
      if (prev_opnd) begin
         syn_c = !(cls == CLS_OP || cls == CLS_RP || cls == CLS_EQ);
      end else begin
         syn_c = !(cls == CLS_OPND || cls == CLS_LP);
      end
      if (cls == CLS_RP && depth == '0)                      syn_c = 1'b1;
      if (cls == CLS_LP && depth == DEPTH_W'(MAX_DEPTH))     syn_c = 1'b1;
      if (cls == CLS_EQ && depth != '0)                      syn_c = 1'b1;
      ovf_c = (cls != CLS_EQ) && (wr_idx == IDX_W'(DEPTH - 1));
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         in_ready  <= 1'b0;
         aec_ready <= 1'b0;
         aec_ascii <= '0;
         busy      <= 1'b0;
         err       <= 1'b0;
         err_code  <= '0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         depth     <= '0;
         timer     <= '0;
         prev_opnd <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) buf_mem[i] <= '0;
      end else begin
         err       <= 1'b0;
         aec_ready <= 1'b0;
         case (state)
            ST_IDLE, ST_COLLECT: begin
               in_ready <= 1'b1;
               if (xfer_c && cls != CLS_SP) begin
                  if (bad_c || syn_c || ovf_c) begin
                     err       <= 1'b1;
                     err_code  <= bad_c ? ERR_ILLEGAL : (syn_c ? ERR_SYNTAX : ERR_OVERFLOW);
                     wr_idx    <= '0;
                     depth     <= '0;
                     prev_opnd <= 1'b0;
                     // A rejected '=' already ends the expression; nothing left to discard
                     state     <= (cls == CLS_EQ) ? ST_IDLE : ST_DISCARD;
                  end else if (cls == CLS_EQ) begin
                     buf_mem[wr_idx] <= in_data;
                     state     <= ST_SEND;
                     in_ready  <= 1'b0;
                     busy      <= 1'b1;
                     aec_ready <= 1'b1;
                     aec_ascii <= buf_mem[0];
                     rd_idx    <= '0;
                  end else begin
                     buf_mem[wr_idx] <= in_data;
                     wr_idx    <= wr_idx + IDX_W'(1);
                     prev_opnd <= (cls == CLS_OPND || cls == CLS_RP);
                     if (cls == CLS_LP) depth <= depth + DEPTH_W'(1);
                     if (cls == CLS_RP) depth <= depth - DEPTH_W'(1);
                     state     <= ST_COLLECT;
                  end
               end
            end
            ST_DISCARD: begin
               in_ready <= 1'b1;
               if (xfer_c && cls == CLS_EQ) begin
                  for (int i = 0; i < int'(DEPTH); i++) buf_mem[i] <= '0;
                  state <= ST_IDLE;
               end
            end
            // wr_idx holds the index of the stored '=' while sending
            ST_SEND: begin
               if (rd_idx == wr_idx) begin
                  state     <= ST_WAIT;
                  aec_ascii <= '0;
                  timer     <= '0;
               end else begin
                  rd_idx    <= rd_nxt_c;
                  aec_ascii <= buf_mem[rd_nxt_c];
               end
            end
            ST_WAIT: begin
               if (aec_valid || timer == TIMER_W'(TIMEOUT - 1)) begin
                  if (!aec_valid) begin
                     err      <= 1'b1;
                     err_code <= ERR_TIMEOUT;
                  end
                  state     <= ST_IDLE;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
                  wr_idx    <= '0;
                  rd_idx    <= '0;
                  depth     <= '0;
                  prev_opnd <= 1'b0;
                  for (int i = 0; i < int'(DEPTH); i++) buf_mem[i] <= '0;
               end else begin
                  timer <= timer + TIMER_W'(1);
               end
            end
            default: begin
               state    <= ST_IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aec_expr_feeder.sv
// Bench for aec_expr_feeder: directed and random expressions checked against
// a grammar-level reference model of the host-to-AEC transfer.
module tb_aec_expr_feeder;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       aec_ready;
   logic [7:0] aec_ascii;
   logic       aec_valid;
   logic       busy;
   logic       err;
   logic [1:0] err_code;

   int n_tests = 0;
   int n_fail  = 0;

   logic [7:0] stim_q[$];
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   logic [1:0] err_q[$];
   int         frames    = 0;
   int         ready_cnt = 0;
   int         ready_bad = 0;
   bit         in_frame  = 0;

   aec_expr_feeder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .aec_ready (aec_ready),
      .aec_ascii (aec_ascii),
      .aec_valid (aec_valid),
      .busy      (busy),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clk = ~clk;

   // Passive observer of what AEC receives and of every error pulse
   always @(negedge clk) begin
      if (!rst) begin
         in_frame = 0;
      end else begin
         if (err) err_q.push_back(err_code);
         if (aec_ready) begin
            ready_cnt++;
            if (in_frame) ready_bad++;
            in_frame = 1;
            got_q.delete();
         end
         if (in_frame) begin
            got_q.push_back(aec_ascii);
            if (aec_ascii == 8'h3D) begin
               in_frame = 0;
               frames++;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load(input string s);
      stim_q.delete();
      for (int i = 0; i < s.len(); i++) stim_q.push_back(s[i]);
   endtask

   // Reference: returns -1 if accepted, else the error code; pos = index of deciding byte
   function automatic int model(output int pos);
      bit want_opnd = 1;
      int lvl = 0;
      exp_q.delete();
      pos = -1;
      for (int i = 0; i < stim_q.size(); i++) begin
         logic [7:0] c;
         bit is_opnd, is_op, legal;
         c = stim_q[i];
         if (c == " ") continue;
         pos     = i;
         is_opnd = (c >= "0" && c <= "9") || (c >= "a" && c <= "f");
         is_op   = (c == "*") || (c == "+") || (c == "-");
         if (!(is_opnd || is_op || c == "(" || c == ")" || c == "=")) return 0;
         legal = want_opnd ? (is_opnd || c == "(") : (is_op || c == ")" || c == "=");
         if (c == "(" && lvl == 7) legal = 0;
         if (c == ")" && lvl == 0) legal = 0;
         if (c == "=" && lvl != 0) legal = 0;
         if (!legal) return 1;
         if (c != "=" && exp_q.size() == 15) return 2;
         exp_q.push_back(c);
         if (c == "=") return -1;
         want_opnd = !(is_opnd || c == ")");
         if (c == "(") lvl++;
         if (c == ")") lvl--;
      end
      return 3;
   endfunction

   // Entered and left on a falling edge; the transfer happens on the rising edge in between
   task automatic put_byte(input logic [7:0] b);
      int g = 0;
      while (!in_ready && g < 400) begin
         @(negedge clk);
         g++;
      end
      if (g >= 400) check("in_ready_wait", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = b;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic run_expr(input string tag, input bit give_valid);
      int code, pos, n, f0, r0, e0, d;
      code = model(pos);
      n  = exp_q.size();
      f0 = frames;
      r0 = ready_cnt;
      e0 = err_q.size();
      for (int i = 0; i < stim_q.size(); i++) begin
         put_byte(stim_q[i]);
         if (code >= 0 && i == pos)
            check({tag, " err_pulse"}, {29'd0, err, err_code}, {29'd0, 1'b1, 2'(code)});
      end
      if (code < 0) begin
         check({tag, " send_start"}, {21'd0, aec_ready, busy, in_ready, aec_ascii},
               {21'd0, 1'b1, 1'b1, 1'b0, exp_q[0]});
         repeat (n) @(negedge clk);
         check({tag, " frames"}, 32'(frames), 32'(f0 + 1));
         check({tag, " ready_pulses"}, 32'(ready_cnt), 32'(r0 + 1));
         check({tag, " no_err"}, 32'(err_q.size()), 32'(e0));
         check({tag, " length"}, 32'(got_q.size()), 32'(n));
         if (got_q.size() == n)
            for (int k = 0; k < n; k++) check({tag, " char"}, 32'(got_q[k]), 32'(exp_q[k]));
         if (give_valid) begin
            d = $urandom_range(0, 20);
            repeat (d) @(negedge clk);
            check({tag, " wait_aec"}, {30'd0, busy, in_ready}, {30'd0, 1'b1, 1'b0});
            aec_valid = 1'b1;
            @(negedge clk);
            aec_valid = 1'b0;
            check({tag, " back_idle"}, {30'd0, busy, in_ready}, {30'd0, 1'b0, 1'b1});
         end
      end else begin
         repeat (2) @(negedge clk);
         check({tag, " err_count"}, 32'(err_q.size()), 32'(e0 + 1));
         if (err_q.size() > e0) check({tag, " err_code"}, 32'(err_q[e0]), 32'(code));
         check({tag, " no_send"}, 32'(ready_cnt), 32'(r0));
         check({tag, " accepting"}, {30'd0, busy, in_ready}, {30'd0, 1'b0, 1'b1});
      end
   endtask

   task automatic push_c(input logic [7:0] c);
      if ($urandom_range(0, 5) == 0) stim_q.push_back(" ");
      stim_q.push_back(c);
   endtask

   task automatic gen_random();
      string digs = "0123456789abcdef";
      string ops  = "*+-";
      string junk = "x(+9)g*!";
      bit want = 1;
      int lvl = 0, len = 0, target;
      stim_q.delete();
      target = $urandom_range(2, 14);
      while (len < target) begin
         if (want) begin
            if (lvl < 7 && $urandom_range(0, 3) == 0) begin
               push_c("(");
               lvl++;
            end else begin
               push_c(digs[$urandom_range(0, 15)]);
               want = 0;
            end
         end else begin
            if (lvl > 0 && $urandom_range(0, 2) == 0) begin
               push_c(")");
               lvl--;
            end else begin
               push_c(ops[$urandom_range(0, 2)]);
               want = 1;
            end
         end
         len++;
      end
      if (want) push_c(digs[$urandom_range(0, 15)]);
      while (lvl > 0) begin
         push_c(")");
         lvl--;
      end
      if ($urandom_range(0, 3) == 0)
         stim_q[$urandom_range(0, stim_q.size() - 1)] = junk[$urandom_range(0, 7)];
      push_c("=");
   endtask

   initial begin
      int k;
      clk       = 1'b0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      aec_valid = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_outputs", {18'd0, in_ready, aec_ready, aec_ascii, busy, err, err_code}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("idle_in_ready", 32'(in_ready), 32'd1);

      load("3+4*(a-2)=");          run_expr("basic", 1);
      load("1 + 2 =");             run_expr("spaces", 1);
      load("2+x=");                run_expr("illegal", 1);
      load("5=");                  run_expr("after_illegal", 1);
      load("(1+2=");               run_expr("open_paren", 1);
      load(")1=");                 run_expr("close_first", 1);
      load("12=");                 run_expr("adjacent_opnd", 1);
      load("0+1+2+3+4+5+6+7+8=");  run_expr("overflow", 1);
      load("0+1+2+3+4+5+6+7=");    run_expr("full_15", 1);
      load("(((((((1)))))))=");    run_expr("depth_7", 1);
      load("((((((((1))))))))=");  run_expr("depth_8", 1);

      // No result from AEC: timeout after 255 waiting cycles
      load("7=");
      run_expr("timeout", 0);
      k = 1;
      while (!err && k < 400) begin
         @(negedge clk);
         k++;
      end
      check("timeout_cycles", 32'(k - 1), 32'd255);
      check("timeout_code", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd3});
      check("timeout_idle", {30'd0, busy, in_ready}, {30'd0, 1'b0, 1'b1});
      @(negedge clk);

      // Reset in the middle of a send
      load("1+2=");
      for (int i = 0; i < stim_q.size(); i++) put_byte(stim_q[i]);
      check("pre_reset_send", {23'd0, aec_ready, aec_ascii}, {23'd0, 1'b1, 8'h31});
      rst = 1'b0;
      @(negedge clk);
      check("mid_send_reset", {21'd0, aec_ready, aec_ascii, busy, in_ready}, 32'd0);
      rst = 1'b1;
      @(negedge clk);
      load("5=");                  run_expr("after_reset", 1);

      for (int r = 0; r < 25; r++) begin
         gen_random();
         run_expr($sformatf("random%0d", r), 1);
      end

      check("ready_only_first", 32'(ready_bad), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
